// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential RV32M multiplier.
// MUL_RADIX4_EN selects two multiplier bits per iteration instead of one.
package mul_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MUL_CTRL   = 3;
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

`ifdef MUL_RADIX4_EN
    localparam int unsigned STEP_BITS = 2;
`else
    localparam int unsigned STEP_BITS = 1;
`endif

    localparam int unsigned MUL_ITERS = DATA_WIDTH / STEP_BITS;
    localparam int unsigned CNT_WIDTH = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10
    } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface mul_seq_if;
    import mul_pkg::*;

    logic                  start;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [MUL_CTRL-1:0]   ctrl;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, op1, op2, ctrl, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op1, op2, ctrl, flush,
        output busy, done, result
    );

endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: adds the multiplicand multiple picked by the low multiplier bits.
// MUL_RADIX4_EN widens the step to two bits using a precomputed 3x multiplicand.
module mul_step
    import mul_pkg::*;
(
    input  logic [PROD_WIDTH-1:0] acc,
    input  logic [PROD_WIDTH-1:0] mcand,
`ifdef MUL_RADIX4_EN
    input  logic [PROD_WIDTH-1:0] mcand3,
`endif
    input  logic [STEP_BITS-1:0]  bits,
    output logic [PROD_WIDTH-1:0] acc_next
);

    logic [PROD_WIDTH-1:0] addend;

    always_comb begin
        addend = '0;
`ifdef MUL_RADIX4_EN
        case (bits)
            2'd0:    addend = '0;
            2'd1:    addend = mcand;
            2'd2:    addend = mcand << 1;
            default: addend = mcand3;
        endcase
`else
        if (bits[0]) begin
            addend = mcand;
        end
`endif
        acc_next = acc + addend;
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential sign-magnitude shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// MUL_RADIX4_EN halves the iteration count; results are unchanged.
module mul_seq
    import mul_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);

    mul_state_e            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [PROD_WIDTH-1:0] acc_q, acc_d;
    logic [PROD_WIDTH-1:0] mcand_q, mcand_d;
`ifdef MUL_RADIX4_EN
    logic [PROD_WIDTH-1:0] mcand3_q, mcand3_d;
`endif
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  sfix_q, sfix_d;
    mul_op_e               op_q, op_d;
    logic                  div_q, div_d;

    logic                  op1_signed, op2_signed;
    logic [DATA_WIDTH-1:0] op1_abs, op2_abs;
    logic [PROD_WIDTH-1:0] mcand_init;
    logic [PROD_WIDTH-1:0] acc_step;
    logic [PROD_WIDTH-1:0] prod;

    // Operand magnitudes; |0x80000000| wraps to 0x80000000, which is 2^31 unsigned.
    always_comb begin
        op1_signed = (bus.ctrl[1:0] != 2'b11);
        op2_signed = !bus.ctrl[1];
        op1_abs    = (op1_signed && bus.op1[DATA_WIDTH-1]) ? -bus.op1 : bus.op1;
        op2_abs    = (op2_signed && bus.op2[DATA_WIDTH-1]) ? -bus.op2 : bus.op2;
        mcand_init = PROD_WIDTH'(op1_abs);
        prod       = sfix_q ? -acc_q : acc_q;
    end

    mul_step u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
`ifdef MUL_RADIX4_EN
        .mcand3   (mcand3_q),
`endif
        .bits     (mplier_q[STEP_BITS-1:0]),
        .acc_next (acc_step)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
`ifdef MUL_RADIX4_EN
        mcand3_d = mcand3_q;
`endif
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sfix_d   = sfix_q;
        op_d     = op_q;
        div_d    = div_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.flush) begin
                    state_d  = BUSY;
                    busy_d   = 1'b1;
                    acc_d    = '0;
                    mcand_d  = mcand_init;
`ifdef MUL_RADIX4_EN
                    mcand3_d = mcand_init + (mcand_init << 1);
`endif
                    mplier_d = op2_abs;
                    cnt_d    = '0;
                    sfix_d   = (op1_signed && bus.op1[DATA_WIDTH-1])
                             ^ (op2_signed && bus.op2[DATA_WIDTH-1]);
                    op_d     = mul_op_e'(bus.ctrl[1:0]);
                    div_d    = bus.ctrl[2];
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << STEP_BITS;
`ifdef MUL_RADIX4_EN
                    mcand3_d = mcand3_q << STEP_BITS;
`endif
                    mplier_d = mplier_q >> STEP_BITS;
                    cnt_d    = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(MUL_ITERS - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        result_d = '0;
                    end else if (op_q == MUL) begin
                        result_d = prod[DATA_WIDTH-1:0];
                    end else begin
                        result_d = prod[PROD_WIDTH-1:DATA_WIDTH];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
`ifdef MUL_RADIX4_EN
            mcand3_q <= '0;
`endif
            mplier_q <= '0;
            cnt_q    <= '0;
            sfix_q   <= 1'b0;
            op_q     <= MUL;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
`ifdef MUL_RADIX4_EN
            mcand3_q <= mcand3_d;
`endif
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sfix_q   <= sfix_d;
            op_q     <= op_d;
            div_q    <= div_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
